// File: rtl/saed32_mem_pkg.sv
// saed32_mem_pkg: SAED32 macro geometry, request classes and RMW sequencer states.
package saed32_mem_pkg;
  localparam int MACRO_W = 22;
  localparam int MACRO_D = 32;
  typedef enum logic [1:0] {READ, FULL_WR, NULL_WR, PART_WR} req_kind_e;
  typedef enum logic {IDLE, WB} rmw_st_e;
  function automatic req_kind_e classify(input logic we, input logic wem_all, input logic wem_none);
    return !we ? READ : wem_all ? FULL_WR : wem_none ? NULL_WR : PART_WR;
  endfunction
endpackage

// File: rtl/SRAM2RW32X22.sv
// SRAM2RW32X22: behavioural stand-in for the SAED32 32x22 dual-port macro (active-low pins, O is 0 while OEB is high).
module SRAM2RW32X22 (
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic        CE1,
  input  logic        CE2,
  input  logic        WEB1,
  input  logic        WEB2,
  input  logic        OEB1,
  input  logic        OEB2,
  input  logic        CSB1,
  input  logic        CSB2,
  input  logic [21:0] I1,
  input  logic [21:0] I2,
  output logic [21:0] O1,
  output logic [21:0] O2
);
  logic [21:0] r_mem [32];
  logic [21:0] r_o1, r_o2;
  always_ff @(posedge CE1) begin
    if (!CSB1 && !WEB1) r_mem[A1] <= I1;
    if (!CSB2 && !WEB2) r_mem[A2] <= I2;
    if (!CSB1 && WEB1) r_o1 <= r_mem[A1];
  end
  always_ff @(posedge CE2)
    if (!CSB2 && WEB2) r_o2 <= r_mem[A2];
  assign O1 = OEB1 ? '0 : r_o1;
  assign O2 = OEB2 ? '0 : r_o2;
endmodule

// File: rtl/saed32_dp_tile.sv
// saed32_dp_tile: one SRAM2RW32X22 driven by active-high request, row-select, write and output-enable controls.
module saed32_dp_tile import saed32_mem_pkg::*; (
  input  logic               CLK,
  input  logic               i_ce0,
  input  logic               i_sel0,
  input  logic               i_we0,
  input  logic               i_oe0,
  input  logic [4:0]         i_a0,
  input  logic [MACRO_W-1:0] i_d0,
  output logic [MACRO_W-1:0] o_q0,
  input  logic               i_ce1,
  input  logic               i_sel1,
  input  logic               i_we1,
  input  logic               i_oe1,
  input  logic [4:0]         i_a1,
  input  logic [MACRO_W-1:0] i_d1,
  output logic [MACRO_W-1:0] o_q1
);
  SRAM2RW32X22 u_sram (
    .A1(i_a0), .A2(i_a1), .CE1(CLK), .CE2(CLK),
    .WEB1(~i_we0), .WEB2(~i_we1), .OEB1(~i_oe0), .OEB2(~i_oe1),
    .CSB1(~(i_ce0 & i_sel0)), .CSB2(~(i_ce1 & i_sel1)),
    .I1(i_d0), .I2(i_d1), .O1(o_q0), .O2(o_q1)
  );
endmodule

// File: rtl/wrap_saed32_dp_rmw.sv
// wrap_saed32_dp_rmw: tiled SAED32 dual-port RAM with per-bit write masks via read-modify-write.
module wrap_saed32_dp_rmw import saed32_mem_pkg::*; #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CE0,
  input  logic             CE1,
  input  logic             WE0,
  input  logic             WE1,
  input  logic [AW-1:0]    A0,
  input  logic [AW-1:0]    A1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] WEM0,
  input  logic [WIDTH-1:0] WEM1,
  output logic             RDY0,
  output logic             RDY1,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic             VLD0,
  output logic             VLD1,
  output logic             COLL
);
  localparam int NC = (WIDTH + MACRO_W - 1) / MACRO_W;
  localparam int NR = DEPTH / MACRO_D;
  localparam int PW = NC * MACRO_W;
  logic [NR-1:0][1:0][PW-1:0] w_o;
  logic [AW-1:0] w_a [2], w_ma [2], r_a [2];
  logic [WIDTH-1:0] w_d [2], w_wem [2], w_old [2], w_merge [2];
  logic [WIDTH-1:0] r_d [2], r_wem [2], r_fwdd [2], r_s1d [2], r_q [2];
  logic [PW-1:0] w_sel [2], w_md [2];
  req_kind_e w_kind [2];
  rmw_st_e r_st [2];
  logic [1:0] w_acc, w_wb, w_go, w_we, r_oe, r_rd, r_fwd, r_s1v, r_vld;
  logic w_rdy, w_drop, r_alive, r_coll;
  // Either port in write-back stalls both, so no request can race a merge.
  assign w_rdy = r_alive && r_st[0] == IDLE && r_st[1] == IDLE;
  assign w_acc = {CE1, CE0} & {2{w_rdy && RSTN}};
  assign w_drop = &w_acc && WE0 && WE1 && A0 == A1;
  always_comb begin
    w_a[0] = A0;
    w_a[1] = A1;
    w_d[0] = D0;
    w_d[1] = D1;
    w_wem[0] = WEM0;
    w_wem[1] = WEM1;
    w_kind[0] = classify(WE0, &WEM0, ~|WEM0);
    w_kind[1] = classify(WE1, &WEM1, ~|WEM1);
    for (int p = 0; p < 2; p++) begin
      w_sel[p] = '0;
      for (int r = 0; r < NR; r++)
        if ((r_a[p] >> 5) == AW'(r)) w_sel[p] = w_o[r][p];
      w_old[p] = w_sel[p][WIDTH-1:0];
      w_merge[p] = (w_old[p] & ~r_wem[p]) | (r_d[p] & r_wem[p]);
      w_wb[p] = r_st[p] == WB;
      w_go[p] = RSTN && (w_wb[p] || (w_acc[p] && w_kind[p] != NULL_WR && !(p == 1 && w_drop)));
      w_we[p] = w_wb[p] || w_kind[p] == FULL_WR;
      w_ma[p] = w_wb[p] ? r_a[p] : w_a[p];
      w_md[p] = PW'(w_wb[p] ? w_merge[p] : w_d[p]);
    end
  end
  for (genvar r = 0; r < NR; r++) begin : g_row
    for (genvar c = 0; c < NC; c++) begin : g_col
      saed32_dp_tile u_tile (
        .CLK,
        .i_ce0(w_go[0]), .i_sel0((w_ma[0] >> 5) == AW'(r)), .i_we0(w_we[0]), .i_oe0(r_oe[0]),
        .i_a0(w_ma[0][4:0]), .i_d0(w_md[0][c*MACRO_W +: MACRO_W]), .o_q0(w_o[r][0][c*MACRO_W +: MACRO_W]),
        .i_ce1(w_go[1]), .i_sel1((w_ma[1] >> 5) == AW'(r)), .i_we1(w_we[1]), .i_oe1(r_oe[1]),
        .i_a1(w_ma[1][4:0]), .i_d1(w_md[1][c*MACRO_W +: MACRO_W]), .o_q1(w_o[r][1][c*MACRO_W +: MACRO_W])
      );
    end
  end
  // Stage 1 captures macro data (or a same-edge forwarded full write); stage 2 is the output register.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_alive <= 1'b0;
      r_coll <= 1'b0;
      r_st <= '{IDLE, IDLE};
      r_oe <= '0;
      r_rd <= '0;
      r_fwd <= '0;
      r_s1v <= '0;
      r_vld <= '0;
      r_q <= '{'0, '0};
    end else begin
      r_alive <= 1'b1;
      r_coll <= w_drop;
      for (int p = 0; p < 2; p++) begin
        r_st[p] <= (w_acc[p] && w_kind[p] == PART_WR && !(p == 1 && w_drop)) ? WB : IDLE;
        if (w_acc[p]) begin
          r_a[p] <= w_a[p];
          r_d[p] <= w_d[p];
          r_wem[p] <= w_wem[p];
        end
        r_oe[p] <= w_go[p] && !w_we[p];
        r_rd[p] <= w_acc[p] && w_kind[p] == READ;
        r_fwd[p] <= w_acc[p] && w_kind[p] == READ && w_acc[1-p] && w_kind[1-p] == FULL_WR && A0 == A1;
        r_fwdd[p] <= w_d[1-p];
        r_s1v[p] <= r_rd[p];
        r_s1d[p] <= r_fwd[p] ? r_fwdd[p] : w_old[p];
        r_vld[p] <= r_s1v[p];
        if (r_s1v[p]) r_q[p] <= r_s1d[p];
      end
    end
  end
  assign RDY0 = w_rdy;
  assign RDY1 = w_rdy;
  assign Q0 = r_q[0];
  assign Q1 = r_q[1];
  assign VLD0 = r_vld[0];
  assign VLD1 = r_vld[1];
  assign COLL = r_coll;
endmodule

// File: tb/tb_wrap_saed32_dp_rmw.sv
// tb_wrap_saed32_dp_rmw: directed plus randomized check of the RMW RAM wrapper against a word-array model.
module tb_wrap_saed32_dp_rmw;
  localparam int W = 40;
  localparam int DP = 64;
  localparam int AW = 6;
  localparam logic [W-1:0] ONES = '1;
  logic clk = 1'b0, rstn = 1'b0;
  logic ce0 = 1'b0, ce1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [W-1:0] d0 = '0, d1 = '0, wem0 = '0, wem1 = '0;
  logic rdy0, rdy1, vld0, vld1, coll;
  logic [W-1:0] q0, q1;
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  wrap_saed32_dp_rmw #(.WIDTH(W), .DEPTH(DP)) dut (
    .CLK(clk), .RSTN(rstn), .CE0(ce0), .CE1(ce1), .WE0(we0), .WE1(we1),
    .A0(a0), .A1(a1), .D0(d0), .D1(d1), .WEM0(wem0), .WEM1(wem1),
    .RDY0(rdy0), .RDY1(rdy1), .Q0(q0), .Q1(q1), .VLD0(vld0), .VLD1(vld1), .COLL(coll)
  );

  // Model: word array, pending masked writes, and read results scheduled by due edge.
  logic [W-1:0] mem [DP];
  bit alive = 0;
  bit pv [2];
  logic [AW-1:0] pa [2];
  logic [W-1:0] pd [2], pw [2];
  bit sv [2][4096];
  logic [W-1:0] sd [2][4096];
  bit exp_rdy = 0, exp_c = 0;
  bit exp_v [2];
  logic [W-1:0] exp_q [2];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit ce [2], we [2], acc [2];
    logic [AW-1:0] a [2];
    logic [W-1:0] d [2], m [2];
    bit same, drop, rdy;
    ce = '{ce0, ce1}; we = '{we0, we1}; a = '{a0, a1}; d = '{d0, d1}; m = '{wem0, wem1};
    exp_c = 0;
    exp_v = '{0, 0};
    if (!rstn) begin
      alive = 0;
      pv = '{0, 0};
      exp_q = '{'0, '0};
      for (int p = 0; p < 2; p++) begin
        sv[p][cyc+1] = 0;
        sv[p][cyc+2] = 0;
      end
    end else begin
      rdy = alive && !pv[0] && !pv[1];
      for (int p = 0; p < 2; p++)
        if (pv[p]) mem[pa[p]] = (mem[pa[p]] & ~pw[p]) | (pd[p] & pw[p]);
      pv = '{0, 0};
      for (int p = 0; p < 2; p++) acc[p] = ce[p] && rdy;
      same = acc[0] && acc[1] && a[0] == a[1];
      drop = same && we[0] && we[1];
      for (int p = 0; p < 2; p++)
        if (acc[p] && !we[p]) begin
          sv[p][cyc+2] = 1;
          sd[p][cyc+2] = (same && we[1-p] && m[1-p] == ONES) ? d[1-p] : mem[a[p]];
        end
      for (int p = 0; p < 2; p++)
        if (acc[p] && we[p] && !(p == 1 && drop)) begin
          if (m[p] == ONES) mem[a[p]] = d[p];
          else if (m[p] != '0) begin
            pv[p] = 1; pa[p] = a[p]; pd[p] = d[p]; pw[p] = m[p];
          end
        end
      exp_c = drop;
      alive = 1;
      for (int p = 0; p < 2; p++)
        if (sv[p][cyc]) begin
          exp_v[p] = 1;
          exp_q[p] = sd[p][cyc];
          sv[p][cyc] = 0;
        end
    end
    exp_rdy = alive && !pv[0] && !pv[1];
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic drv(input int p, input bit c, input bit w, input int a, input logic [W-1:0] d, input logic [W-1:0] m);
    if (p == 0) begin ce0 = c; we0 = w; a0 = AW'(a); d0 = d; wem0 = m; end
    else begin ce1 = c; we1 = w; a1 = AW'(a); d1 = d; wem1 = m; end
  endtask

  task automatic idle();
    ce0 = 1'b0;
    ce1 = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom()});
  endfunction

  function automatic logic [W-1:0] pick_mask();
    int k = $urandom_range(0, 3);
    return k == 0 ? ONES : k == 1 ? '0 : rnd();
  endfunction

  always @(negedge clk) begin
    chk("rdy0", rdy0, exp_rdy);
    chk("rdy1", rdy1, exp_rdy);
    chk("coll", coll, exp_c);
    chk("vld0", vld0, exp_v[0]);
    chk("vld1", vld1, exp_v[1]);
    chk("q0", q0, exp_q[0]);
    chk("q1", q1, exp_q[1]);
  end

  initial begin
    tick(); tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < DP / 2; i++) begin
      drv(0, 1, 1, 2 * i, rnd(), ONES);
      drv(1, 1, 1, 2 * i + 1, rnd(), ONES);
      tick();
    end
    // Full write then read on the other port one edge later.
    idle(); drv(0, 1, 1, 33, 40'hAB_CDEF_0123, ONES); tick();
    idle(); drv(1, 1, 0, 33, '0, '0); tick();
    idle(); tick(); tick();
    @(negedge clk);
    chk("t1_vld1", vld1, 1);
    chk("t1_q1", q1, 40'hAB_CDEF_0123);
    // Partial write stalls both ports for one cycle.
    drv(0, 1, 1, 5, 40'h3F_FFFF, ONES); tick();
    idle(); drv(0, 1, 1, 5, '0, 40'hFF); tick();
    idle();
    @(negedge clk);
    chk("t2_rdy0", rdy0, 0);
    chk("t2_rdy1", rdy1, 0);
    tick();
    @(negedge clk);
    chk("t2_rdy0_back", rdy0, 1);
    drv(0, 1, 0, 5, '0, '0); tick();
    idle(); tick(); tick();
    @(negedge clk);
    chk("t2_q0", q0, 40'h3F_FF00);
    // Write/write collision: port 0 wins.
    drv(0, 1, 1, 7, 40'h1, ONES); drv(1, 1, 1, 7, 40'h2, ONES); tick();
    idle();
    @(negedge clk);
    chk("t3_coll", coll, 1);
    drv(0, 1, 0, 7, '0, '0); tick();
    idle(); tick(); tick();
    @(negedge clk);
    chk("t3_q0", q0, 40'h1);
    // Read forwarded from a same-edge full write.
    drv(0, 1, 1, 9, 40'h155, ONES); drv(1, 1, 0, 9, '0, '0); tick();
    idle(); tick(); tick();
    @(negedge clk);
    chk("t4_q1", q1, 40'h155);
    // Null write leaves the word untouched.
    drv(1, 1, 1, 12, 40'h1234, ONES); tick();
    idle(); drv(1, 1, 1, 12, 40'hFF_FFFF_FFFF, '0); tick();
    idle();
    @(negedge clk);
    chk("t5_coll", coll, 0);
    chk("t5_vld1", vld1, 0);
    drv(1, 1, 0, 12, '0, '0); tick();
    idle(); tick(); tick();
    @(negedge clk);
    chk("t5_q1", q1, 40'h1234);
    // Reset during write-back abandons the merge.
    drv(0, 1, 1, 20, 40'h0F0F, ONES); tick();
    idle(); drv(0, 1, 1, 20, 40'hAA, 40'hFF); tick();
    idle(); rstn = 1'b0; tick();
    @(negedge clk);
    chk("t6_q0", q0, 0);
    chk("t6_q1", q1, 0);
    chk("t6_vld0", vld0, 0);
    chk("t6_rdy0", rdy0, 0);
    chk("t6_rdy1", rdy1, 0);
    rstn = 1'b1; tick();
    @(negedge clk);
    chk("t6_rdy0_rel", rdy0, 1);
    chk("t6_rdy1_rel", rdy1, 1);
    drv(0, 1, 0, 20, '0, '0); tick();
    idle(); tick(); tick();
    @(negedge clk);
    chk("t6_q0_kept", q0, 40'h0F0F);
    // Randomized traffic, narrow address range for frequent collisions.
    for (int n = 0; n < 2000; n++) begin
      rstn = ($urandom_range(0, 99) != 0);
      for (int p = 0; p < 2; p++)
        drv(p, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0) ? $urandom_range(0, 7) : $urandom_range(0, DP - 1),
            rnd(), pick_mask());
      tick();
    end
    rstn = 1'b1;
    idle();
    repeat (4) tick();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wrap_saed32_dp_rmw.md
# wrap_saed32_dp_rmw

Parametrised dual-port RAM wrapper for the SAED32 flow that tiles `SRAM2RW32X22` macros to any multiple of 32 words and any word width. It adds true per-bit write masking through a read-modify-write sequencer, a registered output stage with valid strobes, and deterministic same-address collision rules. It sits between Mnemosyne-generated memory interfaces and the SAED32 hard macros, and replaces fixed-size per-macro wrappers.

## Interface
- `WIDTH`, default 22: data word width in bits, at least 1.
- `DEPTH`, default 32: number of words, a multiple of 32.
- `AW`, default `$clog2(DEPTH)`: address width; derived, do not override.
- `CLK` input, 1 bit: the single clock. All macros and registers use its rising edge.
- `RSTN` input, 1 bit: reset, synchronous and active-low.
- `CE0`, `CE1` input, 1 bit each: port request, active-high.
- `WE0`, `WE1` input, 1 bit each: 1 means write, 0 means read. Only meaningful when CE is high.
- `A0`, `A1` input, `AW` bits each: word address.
- `D0`, `D1` input, `WIDTH` bits each: write data.
- `WEM0`, `WEM1` input, `WIDTH` bits each: per-bit write enable, 1 means write that bit.
- `RDY0`, `RDY1` output, 1 bit each: port can accept a request this cycle.
- `Q0`, `Q1` output, `WIDTH` bits each: registered read data.
- `VLD0`, `VLD1` output, 1 bit each: one-cycle pulse marking `Q` as valid.
- `COLL` output, 1 bit: one-cycle pulse when a port-1 write is dropped.

## Operation
- A request is accepted on a port when CE and RDY are both high at a rising edge. A request while RDY is low is ignored; the requester must hold it.
- Tiling:
  - Number of column tiles = ceil(WIDTH/22).
  - Number of row tiles = DEPTH/32.
  - `A[4:0]` addresses within a macro; `A[AW-1:5]` selects the row tile.
  - Unused macro bits are written 0 and masked off on read.
  - Only the selected row tile receives an active CSB.
- Request classes, per port:
  - Read: macro read, then `Q`/`VLD` asserted.
  - Full write (`WEM` all ones): single-cycle macro write.
  - Null write (`WEM` all zeros): accepted; no macro access, no VLD.
  - Partial write (any other `WEM`): read-modify-write.
- Read-modify-write sequencer, one per port, states IDLE and WB:
  - IDLE: an accepted partial write issues a macro read, latches A, D and WEM, and moves to WB.
  - WB: merges `(old & ~WEM) | (D & WEM)` and issues the macro write. RDYp is 0. Always returns to IDLE.
- Global lock: while either port is in WB, the other port's RDY is also 0. This removes RMW hazards.
- Collisions, when both ports are accepted with the same address:
  - Write/write: port 0 wins and port 1's write is dropped. COLL pulses. This includes a null or partial write on port 1.
  - Read on one port with a full write on the other: the read returns the newly written data, forwarded in the output stage.
  - Read/read: both ports return the stored data.
- Macro pin mapping:
  - CSB = ~(accepted & row selected).
  - WEB = ~write.
  - OEB = 0 on the cycle the read data is used.
  - The macro CE pins are tied to `CLK`.

## Timing
- Reset values, held while `RSTN` is 0 at an edge:
  - `Q0` = `Q1` = 0, `VLD0` = `VLD1` = 0, `COLL` = 0.
  - `RDY0` = `RDY1` = 0 during reset; both are 1 on the first cycle after reset.
  - Both sequencers are in IDLE.
  - Memory contents are not reset.
- Read latency: accepted at edge t gives `Q`/`VLD` valid after edge t+2 (macro stage plus output register).
- Full write: memory is updated at edge t. A read accepted at edge t+1 sees the new data.
- Partial write: accepted at edge t; the merged write is issued at edge t+1. RDY0 and RDY1 are both 0 during the cycle between edges t and t+1. The port may accept again at edge t+2.
- Back-to-back reads are allowed at one per cycle per port with full throughput.
- `COLL` is asserted in the cycle after the colliding edge.
- Reset during WB: the pending write-back is abandoned and the memory word keeps its old value.
- Q holds its last value when no read completes.

## Structure
- Package `saed32_mem_pkg` holds:
  - Macro constants `MACRO_W` = 22 and `MACRO_D` = 32.
  - A `req_kind_e` enum {READ, FULL_WR, NULL_WR, PART_WR}.
  - A function `classify(we, wem)`.
- Sub-module `saed32_dp_tile`:
  - Instantiates one `SRAM2RW32X22`.
  - Maps active-high CE/WE/row-select onto CSB/WEB/OEB.
  - Generated as a row × column array in the top level.
- Top level contains the two RMW sequencers, the collision/forward logic, and the output registers.

## Test plan
- WIDTH=40, DEPTH=64: full write A0=33, D0=0xAB_CDEF_0123. A port-1 read of 33 at the next edge gives Q1 = 0xAB_CDEF_0123 with VLD1 two edges after acceptance.
- Partial write:
  - Preload word 5 = 0x3FFFFF (WIDTH=22).
  - Write D0=0, WEM0=0x0000FF.
  - RDY0 and RDY1 are both 0 for one cycle.
  - A subsequent read of word 5 returns 0x3FFF00.
- Both ports perform full writes to address 7 in the same cycle (D0=0x1, D1=0x2). COLL pulses, and a later read of address 7 returns 0x1.
- Port 0 full-writes 0x155 to address 9 while port 1 reads 9 in the same cycle. Q1 = 0x155.
- Null write with WEM1=0 to a preloaded word leaves it unchanged; no VLD1 and no COLL.
- Reset sequence:
  - Assert `RSTN` = 0 during WB of a partial write.
  - All outputs go to 0 and the target word keeps its old value.
  - After release, RDY0 = RDY1 = 1.
